riscv_decode_stage: RTL and testbench
=====================================

// Module: riscv_decode_stage
// PURPOSE
//  Pipelined, handshaked RV32I decode stage between fetch and execute.
//  Registers the decoded fields behind a 2-entry skid buffer (out + skid) so it sustains 1 instr/cycle.
//  Holds RAW hazards with a busy-bit register scoreboard, which the writeback clears.
// PARAMETERS
//  XLEN    32  immediate_value width; immediates are sign-extended to XLEN (XLEN >= 32)
//  REG_AW  5   register address width; 5 = RV32I, 4 = RV32E (rs/rd field bit 4 set -> illegal)
// PORTS
//  clk              in   1        clock; all state on rising edge
//  reset            in   1        asynchronous, active-high reset
//  flush            in   1        sync: drop out and skid entries (scoreboard kept)
//  in_valid         in   1        Instr valid
//  in_ready         out  1        stage can accept; = ~skid_full (registered, no comb path from in_*)
//  Instr            in   32       raw instruction
//  out_valid        out  1        decoded entry valid and hazard-free
//  out_ready        in   1        execute accepts
//  src_reg_addr0    out  REG_AW   rs1, 0 if unused
//  src_reg_addr1    out  REG_AW   rs2, 0 if unused
//  dst_reg_addr     out  REG_AW   rd, 0 for STORE/BRANCH/illegal
//  ALU_control      out  4        0 ADD,1 SUB,2 SLL,3 SLT,4 SLTU,5 XOR,6 SRL,7 SRA,8 OR,9 AND
//  control_signal   out  4        0 R,1 I-ALU,2 LOAD,3 STORE,4 BRANCH,5 AUIPC,6 LUI,7 JAL,8 JALR,15 ILLEGAL
//  immediate_value  out  XLEN     sign-extended I/S/B/U/J immediate; 0 for R/illegal
//  illegal          out  1        1 when control_signal==15
//  wb_valid         in   1        writeback retiring a destination
//  wb_addr          in   REG_AW   register to clear in scoreboard
// BEHAVIOUR
//  Reset: out_valid=0, in_ready=1, all decoded outputs 0, illegal=0, both entries empty, busy[] all 0.
//  Decode is combinational on Instr and captured at accept (in_valid & in_ready). Latency: accept in cycle N -> out_valid earliest N+1.
//  Opcodes (standard RV32I): 0110011 R, 0010011 I, 0000011 LOAD, 0100011 STORE, 1100011 BRANCH,
//   0010111 AUIPC, 0110111 LUI, 1101111 JAL, 1100111 JALR. Anything else is ILLEGAL.
//  ILLEGAL also covers: R with funct7 not 0000000/0100000 (0100000 only for funct3 000/101);
//   slli/srli/srai with bad funct7; BRANCH funct3 010/011; JALR funct3!=0; REG_AW=4 with a used reg field >=16.
//  ALU: R/I use funct3 (+Instr[30] for SUB/SRA/SRAI; ADDI never SUB); BRANCH -> SUB; all others -> ADD.
//  rs1 used: R,I,LOAD,STORE,BRANCH,JALR. rs2 used: R,STORE,BRANCH. rd used: R,I,LOAD,AUIPC,LUI,JAL,JALR.
//  Skid: accept goes to out if out is empty or firing this cycle, else to skid. When out fires with skid full, skid -> out.
//   in_ready falls the cycle after skid fills. Strict FIFO order is preserved.
//  Hazard: hazard = out_full & ((rs1 used & rs1!=0 & busy[rs1]) | (rs2 used & rs2!=0 & busy[rs2])).
//   out_valid = out_full & ~hazard. Decoded outputs stay stable while out_valid=0 or out_ready=0.
//  Fire (out_valid & out_ready) with rd used & rd!=0 sets busy[rd] next edge.
//  wb_valid clears busy[wb_addr] next edge; the hazard releases one cycle after wb (out_valid rises N+1 after wb in N).
//  A set and a clear of the same register in one cycle: the set wins. wb to x0 is ignored; busy[0] is never set.
//  flush: next edge out/skid empty, out_valid=0, in_ready=1. An in_valid in the flush cycle is dropped. busy[] is untouched.
//  Async reset mid-stream clears everything immediately, independent of clk.
// TESTING
//  1 ADDI x1,x2,5 (0x00510093), out_ready=1 -> next cycle out_valid=1, ctrl=1, ALU=0, src0=2, src1=0, dst=1, imm=0x5.
//  2 Then SUB x3,x1,x2 (0x402081B3) -> out_valid=0 (busy x1). wb_valid=1,wb_addr=1 in cycle N -> out_valid=1 in N+1, ALU=1, ctrl=0.
//  3 BEQ x0,x0,-4 (0xFE000EE3) -> ctrl=4, ALU=1, dst=0, imm=0xFFFFFFFC. LUI x5,0x12345 (0x123452B7) -> ctrl=6, imm=0x12345000.
//  4 Instr=0x00000000 and SUB-coded funct7 on XOR -> ctrl=15, illegal=1, dst=0, imm=0. REG_AW=4: ADDI x17,x0,1 -> illegal.
//  5 out_ready=0, send 3 instrs back-to-back -> 2 accepted, then in_ready=0. Release -> all 3 emerge in order at 1/cycle.
//  6 flush with both entries full, and async reset mid-stream -> out_valid=0, in_ready=1. Scoreboard kept on flush, cleared on reset.

Source files
------------

// File: rtl/riscv_decode_stage.sv
// RV32I decode stage: combinational decode captured into a two-entry skid buffer,
// with a busy-bit scoreboard that holds RAW hazards until writeback clears them.
module riscv_decode_stage #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned REG_AW = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       Instr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [REG_AW-1:0] src_reg_addr0,
  output logic [REG_AW-1:0] src_reg_addr1,
  output logic [REG_AW-1:0] dst_reg_addr,
  output logic [3:0]        ALU_control,
  output logic [3:0]        control_signal,
  output logic [XLEN-1:0]   immediate_value,
  output logic              illegal,
  input  logic              wb_valid,
  input  logic [REG_AW-1:0] wb_addr
);

  localparam int unsigned NumRegs    = 1 << REG_AW;
  localparam bit          NarrowRegs = (REG_AW < 5);

  localparam logic [6:0] OpR      = 7'b0110011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;

  localparam logic [3:0] CtrlR       = 4'd0;
  localparam logic [3:0] CtrlImm     = 4'd1;
  localparam logic [3:0] CtrlLoad    = 4'd2;
  localparam logic [3:0] CtrlStore   = 4'd3;
  localparam logic [3:0] CtrlBranch  = 4'd4;
  localparam logic [3:0] CtrlAuipc   = 4'd5;
  localparam logic [3:0] CtrlLui     = 4'd6;
  localparam logic [3:0] CtrlJal     = 4'd7;
  localparam logic [3:0] CtrlJalr    = 4'd8;
  localparam logic [3:0] CtrlIllegal = 4'd15;

  localparam logic [3:0] AluAdd  = 4'd0;
  localparam logic [3:0] AluSub  = 4'd1;
  localparam logic [3:0] AluSll  = 4'd2;
  localparam logic [3:0] AluSlt  = 4'd3;
  localparam logic [3:0] AluSltu = 4'd4;
  localparam logic [3:0] AluXor  = 4'd5;
  localparam logic [3:0] AluSrl  = 4'd6;
  localparam logic [3:0] AluSra  = 4'd7;
  localparam logic [3:0] AluOr   = 4'd8;
  localparam logic [3:0] AluAnd  = 4'd9;

  typedef struct packed {
    logic [REG_AW-1:0] src0;
    logic [REG_AW-1:0] src1;
    logic [REG_AW-1:0] dst;
    logic [3:0]        alu;
    logic [3:0]        ctrl;
    logic [XLEN-1:0]   imm;
  } entry_t;

  function automatic logic [3:0] alu_of(input logic [2:0] f3, input logic alt);
    logic [3:0] op;
    case (f3)
      3'b000:  op = alt ? AluSub : AluAdd;
      3'b001:  op = AluSll;
      3'b010:  op = AluSlt;
      3'b011:  op = AluSltu;
      3'b100:  op = AluXor;
      3'b101:  op = alt ? AluSra : AluSrl;
      3'b110:  op = AluOr;
      default: op = AluAnd;
    endcase
    return op;
  endfunction

  // Instruction fields and immediates
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  rs1_f;
  logic [4:0]  rs2_f;
  logic [4:0]  rd_f;
  logic [31:0] i_imm;
  logic [31:0] s_imm;
  logic [31:0] b_imm;
  logic [31:0] u_imm;
  logic [31:0] j_imm;

  assign opcode = Instr[6:0];
  assign rd_f   = Instr[11:7];
  assign funct3 = Instr[14:12];
  assign rs1_f  = Instr[19:15];
  assign rs2_f  = Instr[24:20];
  assign funct7 = Instr[31:25];

  assign i_imm = {{20{Instr[31]}}, Instr[31:20]};
  assign s_imm = {{20{Instr[31]}}, Instr[31:25], Instr[11:7]};
  assign b_imm = {{19{Instr[31]}}, Instr[31], Instr[7], Instr[30:25], Instr[11:8], 1'b0};
  assign u_imm = {Instr[31:12], 12'b0};
  assign j_imm = {{11{Instr[31]}}, Instr[31], Instr[19:12], Instr[20], Instr[30:21], 1'b0};

  logic        use_rs1;
  logic        use_rs2;
  logic        use_rd;
  logic        legal;
  logic [3:0]  dec_ctrl;
  logic [3:0]  dec_alu;
  logic [31:0] dec_imm32;
  entry_t      dec;

  always_comb begin
    use_rs1   = 1'b0;
    use_rs2   = 1'b0;
    use_rd    = 1'b0;
    legal     = 1'b1;
    dec_ctrl  = CtrlIllegal;
    dec_alu   = AluAdd;
    dec_imm32 = '0;
    case (opcode)
      OpR: begin
        dec_ctrl = CtrlR;
        use_rs1  = 1'b1;
        use_rs2  = 1'b1;
        use_rd   = 1'b1;
        if (funct7 == 7'b0000000) begin
          dec_alu = alu_of(funct3, 1'b0);
        end else if (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101)) begin
          dec_alu = alu_of(funct3, 1'b1);
        end else begin
          legal = 1'b0;
        end
      end
      OpImm: begin
        dec_ctrl  = CtrlImm;
        use_rs1   = 1'b1;
        use_rd    = 1'b1;
        dec_imm32 = i_imm;
        // Only the shift-right immediate can carry the arithmetic bit; ADDI never subtracts.
        dec_alu   = alu_of(funct3, (funct3 == 3'b101) && Instr[30]);
        if (funct3 == 3'b001 && funct7 != 7'b0000000) legal = 1'b0;
        if (funct3 == 3'b101 && funct7 != 7'b0000000 && funct7 != 7'b0100000) legal = 1'b0;
      end
      OpLoad: begin
        dec_ctrl  = CtrlLoad;
        use_rs1   = 1'b1;
        use_rd    = 1'b1;
        dec_imm32 = i_imm;
      end
      OpStore: begin
        dec_ctrl  = CtrlStore;
        use_rs1   = 1'b1;
        use_rs2   = 1'b1;
        dec_imm32 = s_imm;
      end
      OpBranch: begin
        dec_ctrl  = CtrlBranch;
        use_rs1   = 1'b1;
        use_rs2   = 1'b1;
        dec_alu   = AluSub;
        dec_imm32 = b_imm;
        if (funct3 == 3'b010 || funct3 == 3'b011) legal = 1'b0;
      end
      OpAuipc: begin
        dec_ctrl  = CtrlAuipc;
        use_rd    = 1'b1;
        dec_imm32 = u_imm;
      end
      OpLui: begin
        dec_ctrl  = CtrlLui;
        use_rd    = 1'b1;
        dec_imm32 = u_imm;
      end
      OpJal: begin
        dec_ctrl  = CtrlJal;
        use_rd    = 1'b1;
        dec_imm32 = j_imm;
      end
      OpJalr: begin
        dec_ctrl  = CtrlJalr;
        use_rs1   = 1'b1;
        use_rd    = 1'b1;
        dec_imm32 = i_imm;
        if (funct3 != 3'b000) legal = 1'b0;
      end
      default: legal = 1'b0;
    endcase
    // RV32E has only 16 registers: any used field reaching x16..x31 is illegal.
    if (NarrowRegs && ((use_rs1 && rs1_f[4]) || (use_rs2 && rs2_f[4]) || (use_rd && rd_f[4]))) begin
      legal = 1'b0;
    end
  end

  always_comb begin
    dec      = '0;
    dec.ctrl = CtrlIllegal;
    if (legal) begin
      dec.src0 = use_rs1 ? rs1_f[REG_AW-1:0] : '0;
      dec.src1 = use_rs2 ? rs2_f[REG_AW-1:0] : '0;
      dec.dst  = use_rd ? rd_f[REG_AW-1:0] : '0;
      dec.alu  = dec_alu;
      dec.ctrl = dec_ctrl;
      dec.imm  = XLEN'($signed(dec_imm32));
    end
  end

  // Skid buffer and scoreboard state
  entry_t               out_q, out_d;
  entry_t               skid_q, skid_d;
  logic                 out_full_q, out_full_d;
  logic                 skid_full_q, skid_full_d;
  logic [NumRegs-1:0]   busy_q, busy_d;
  logic                 hazard;
  logic                 fire;
  logic                 accept;

  // busy_q[0] is never set, so x0 and unused (zeroed) sources never stall.
  assign hazard    = out_full_q & (busy_q[out_q.src0] | busy_q[out_q.src1]);
  assign out_valid = out_full_q & ~hazard;
  assign in_ready  = ~skid_full_q;
  assign fire      = out_valid & out_ready;
  assign accept    = in_valid & in_ready;

  always_comb begin
    out_d       = out_q;
    skid_d      = skid_q;
    out_full_d  = out_full_q;
    skid_full_d = skid_full_q;
    if (flush) begin
      out_full_d  = 1'b0;
      skid_full_d = 1'b0;
    end else if (fire) begin
      // in_ready is low whenever skid is full, so no accept can coincide with the skid drain.
      if (skid_full_q) begin
        out_d       = skid_q;
        skid_full_d = 1'b0;
      end else if (accept) begin
        out_d = dec;
      end else begin
        out_full_d = 1'b0;
      end
    end else if (accept) begin
      if (out_full_q) begin
        skid_d      = dec;
        skid_full_d = 1'b1;
      end else begin
        out_d      = dec;
        out_full_d = 1'b1;
      end
    end
  end

  always_comb begin
    busy_d = busy_q;
    if (wb_valid) busy_d[wb_addr] = 1'b0;
    // Applied after the clear so a same-cycle set of the same register wins.
    if (fire && out_q.dst != '0) busy_d[out_q.dst] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_q       <= '0;
      skid_q      <= '0;
      out_full_q  <= 1'b0;
      skid_full_q <= 1'b0;
      busy_q      <= '0;
    end else begin
      out_q       <= out_d;
      skid_q      <= skid_d;
      out_full_q  <= out_full_d;
      skid_full_q <= skid_full_d;
      busy_q      <= busy_d;
    end
  end

  assign src_reg_addr0   = out_q.src0;
  assign src_reg_addr1   = out_q.src1;
  assign dst_reg_addr    = out_q.dst;
  assign ALU_control     = out_q.alu;
  assign control_signal  = out_q.ctrl;
  assign immediate_value = out_q.imm;
  assign illegal         = (out_q.ctrl == CtrlIllegal);

endmodule

// File: tb/tb_riscv_decode_stage.sv
// Bench for riscv_decode_stage: directed cases plus random traffic checked against
// a queue-and-busy-array model with an arithmetic reference decoder.
module tb_riscv_decode_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] Instr;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  src_reg_addr0;
  logic [4:0]  src_reg_addr1;
  logic [4:0]  dst_reg_addr;
  logic [3:0]  ALU_control;
  logic [3:0]  control_signal;
  logic [31:0] immediate_value;
  logic        illegal;
  logic        wb_valid;
  logic [4:0]  wb_addr;

  // RV32E instance
  logic        e_in_valid;
  logic        e_in_ready;
  logic [31:0] e_instr;
  logic        e_out_valid;
  logic [3:0]  e_src0;
  logic [3:0]  e_src1;
  logic [3:0]  e_dst;
  logic [3:0]  e_alu;
  logic [3:0]  e_ctrl;
  logic [31:0] e_imm;
  logic        e_illegal;

  always #5 clk = ~clk;

  riscv_decode_stage #(.XLEN(32), .REG_AW(5)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .Instr(Instr),
    .out_valid(out_valid), .out_ready(out_ready),
    .src_reg_addr0(src_reg_addr0), .src_reg_addr1(src_reg_addr1), .dst_reg_addr(dst_reg_addr),
    .ALU_control(ALU_control), .control_signal(control_signal),
    .immediate_value(immediate_value), .illegal(illegal),
    .wb_valid(wb_valid), .wb_addr(wb_addr)
  );

  riscv_decode_stage #(.XLEN(32), .REG_AW(4)) dut_e (
    .clk(clk), .reset(reset), .flush(1'b0),
    .in_valid(e_in_valid), .in_ready(e_in_ready), .Instr(e_instr),
    .out_valid(e_out_valid), .out_ready(1'b1),
    .src_reg_addr0(e_src0), .src_reg_addr1(e_src1), .dst_reg_addr(e_dst),
    .ALU_control(e_alu), .control_signal(e_ctrl),
    .immediate_value(e_imm), .illegal(e_illegal),
    .wb_valid(1'b0), .wb_addr(4'd0)
  );

  typedef struct packed {
    logic [4:0]  s0;
    logic [4:0]  s1;
    logic [4:0]  d;
    logic [3:0]  alu;
    logic [3:0]  ctrl;
    logic [31:0] imm;
  } exp_t;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t mq[$];
  bit   mbusy[32];
  int   alu_tab[8] = '{0, 2, 3, 4, 5, 6, 8, 9};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%08h exp=0x%08h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t ref_decode(input logic [31:0] ins);
    exp_t e;
    int op, f3, f7, si, r1, r2, rd, alu, ctrl, imm;
    bit ok, u1, u2, ud;
    op = int'(ins & 32'h7f);
    rd = int'((ins >> 7) & 32'h1f);
    f3 = int'((ins >> 12) & 32'h7);
    r1 = int'((ins >> 15) & 32'h1f);
    r2 = int'((ins >> 20) & 32'h1f);
    f7 = int'(ins >> 25);
    si = int'(ins);
    ok = 1; u1 = 0; u2 = 0; ud = 0; alu = 0; ctrl = 0; imm = 0;
    case (op)
      'h33: begin
        ctrl = 0; u1 = 1; u2 = 1; ud = 1;
        if (f7 == 0) alu = alu_tab[f3];
        else if (f7 == 32 && (f3 == 0 || f3 == 5)) alu = alu_tab[f3] + 1;
        else ok = 0;
      end
      'h13: begin
        ctrl = 1; u1 = 1; ud = 1; imm = si >>> 20; alu = alu_tab[f3];
        if (f3 == 1 && f7 != 0) ok = 0;
        if (f3 == 5) begin
          if (f7 == 32) alu = 7;
          else if (f7 != 0) ok = 0;
        end
      end
      'h03: begin ctrl = 2; u1 = 1; ud = 1; imm = si >>> 20; end
      'h23: begin ctrl = 3; u1 = 1; u2 = 1; imm = (si >>> 25) * 32 + rd; end
      'h63: begin
        ctrl = 4; u1 = 1; u2 = 1; alu = 1;
        imm = (si < 0 ? -4096 : 0) + int'((ins >> 7) & 1) * 2048
            + int'((ins >> 25) & 63) * 32 + int'((ins >> 8) & 15) * 2;
        if (f3 == 2 || f3 == 3) ok = 0;
      end
      'h17: begin ctrl = 5; ud = 1; imm = int'(ins & 32'hFFFFF000); end
      'h37: begin ctrl = 6; ud = 1; imm = int'(ins & 32'hFFFFF000); end
      'h6f: begin
        ctrl = 7; ud = 1;
        imm = (si < 0 ? -1048576 : 0) + int'((ins >> 12) & 255) * 4096
            + int'((ins >> 20) & 1) * 2048 + int'((ins >> 21) & 1023) * 2;
      end
      'h67: begin
        ctrl = 8; u1 = 1; ud = 1; imm = si >>> 20;
        if (f3 != 0) ok = 0;
      end
      default: ok = 0;
    endcase
    e = '0;
    if (!ok) begin
      e.ctrl = 4'd15;
    end else begin
      e.s0   = u1 ? 5'(r1) : 5'd0;
      e.s1   = u2 ? 5'(r2) : 5'd0;
      e.d    = ud ? 5'(rd) : 5'd0;
      e.alu  = 4'(alu);
      e.ctrl = 4'(ctrl);
      e.imm  = 32'(imm);
    end
    return e;
  endfunction

  task automatic drive(input logic iv, input logic [31:0] ins, input logic ordy,
                       input logic wv, input logic [4:0] wa, input logic fl);
    in_valid = iv; Instr = ins; out_ready = ordy; wb_valid = wv; wb_addr = wa; flush = fl;
  endtask

  // Compare against the model at the negedge, advance the model, return at posedge+1.
  task automatic tick();
    exp_t h;
    bit   ev, er, fire, acc;
    @(negedge clk);
    h  = '0;
    er = (mq.size() < 2);
    ev = 1'b0;
    if (mq.size() > 0) begin
      h  = mq[0];
      ev = !(mbusy[h.s0] || mbusy[h.s1]);
      check_eq("src0", 32'(src_reg_addr0), 32'(h.s0));
      check_eq("src1", 32'(src_reg_addr1), 32'(h.s1));
      check_eq("dst", 32'(dst_reg_addr), 32'(h.d));
      check_eq("alu", 32'(ALU_control), 32'(h.alu));
      check_eq("ctrl", 32'(control_signal), 32'(h.ctrl));
      check_eq("imm", immediate_value, h.imm);
      check_eq("illegal", 32'(illegal), 32'(h.ctrl == 4'd15));
    end
    check_eq("in_ready", 32'(in_ready), 32'(er));
    check_eq("out_valid", 32'(out_valid), 32'(ev));
    fire = ev && out_ready;
    acc  = in_valid && er;
    if (fire) void'(mq.pop_front());
    if (wb_valid) mbusy[wb_addr] = 1'b0;
    if (fire && h.d != 5'd0) mbusy[h.d] = 1'b1;
    if (flush) mq.delete();
    else if (acc) mq.push_back(ref_decode(Instr));
    @(posedge clk);
    #1;
  endtask

  task automatic wb_clear(input logic [4:0] r);
    drive(1'b0, 32'h0, 1'b1, 1'b1, r, 1'b0);
    tick();
  endtask

  initial begin
    logic [31:0] ins;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 5'd0, 1'b0);
    e_in_valid = 1'b0; e_instr = 32'h0;
    reset = 1'b1;
    foreach (mbusy[i]) mbusy[i] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_in_ready", 32'(in_ready), 32'd1);
    check_eq("rst_fields", {17'(src_reg_addr0), 5'(dst_reg_addr), 4'(ALU_control),
                            2'(control_signal)}, 32'd0);
    check_eq("rst_imm", immediate_value, 32'd0);
    check_eq("rst_illegal", 32'(illegal), 32'd0);
    reset = 1'b0;

    // ADDI x1,x2,5 then SUB x3,x1,x2 held by the scoreboard until wb of x1
    drive(1'b1, 32'h00510093, 1'b1, 1'b0, 5'd0, 1'b0); tick();
    drive(1'b1, 32'h402081B3, 1'b1, 1'b0, 5'd0, 1'b0);
    check_eq("t1_valid", 32'(out_valid), 32'd1);
    check_eq("t1_ctrl", 32'(control_signal), 32'd1);
    check_eq("t1_alu", 32'(ALU_control), 32'd0);
    check_eq("t1_src0", 32'(src_reg_addr0), 32'd2);
    check_eq("t1_src1", 32'(src_reg_addr1), 32'd0);
    check_eq("t1_dst", 32'(dst_reg_addr), 32'd1);
    check_eq("t1_imm", immediate_value, 32'h5);
    tick();
    drive(1'b0, 32'h0, 1'b1, 1'b0, 5'd0, 1'b0);
    check_eq("t2_hazard", 32'(out_valid), 32'd0);
    tick();
    drive(1'b0, 32'h0, 1'b1, 1'b1, 5'd1, 1'b0);
    check_eq("t2_hazard_wb", 32'(out_valid), 32'd0);
    tick();
    drive(1'b0, 32'h0, 1'b1, 1'b0, 5'd0, 1'b0);
    check_eq("t2_release", 32'(out_valid), 32'd1);
    check_eq("t2_alu", 32'(ALU_control), 32'd1);
    check_eq("t2_ctrl", 32'(control_signal), 32'd0);
    tick();
    wb_clear(5'd3);

    // BEQ and LUI
    drive(1'b1, 32'hFE000EE3, 1'b1, 1'b0, 5'd0, 1'b0); tick();
    drive(1'b1, 32'h123452B7, 1'b1, 1'b0, 5'd0, 1'b0);
    check_eq("t3_beq_ctrl", 32'(control_signal), 32'd4);
    check_eq("t3_beq_alu", 32'(ALU_control), 32'd1);
    check_eq("t3_beq_dst", 32'(dst_reg_addr), 32'd0);
    check_eq("t3_beq_imm", immediate_value, 32'hFFFFFFFC);
    tick();
    drive(1'b0, 32'h0, 1'b1, 1'b0, 5'd0, 1'b0);
    check_eq("t3_lui_ctrl", 32'(control_signal), 32'd6);
    check_eq("t3_lui_imm", immediate_value, 32'h12345000);
    tick();
    wb_clear(5'd5);

    // Illegal encodings
    drive(1'b1, 32'h00000000, 1'b1, 1'b0, 5'd0, 1'b0); tick();
    drive(1'b1, 32'h4020C1B3, 1'b1, 1'b0, 5'd0, 1'b0);
    check_eq("t4_zero_ctrl", 32'(control_signal), 32'd15);
    check_eq("t4_zero_ill", 32'(illegal), 32'd1);
    tick();
    drive(1'b0, 32'h0, 1'b1, 1'b0, 5'd0, 1'b0);
    check_eq("t4_xor_ctrl", 32'(control_signal), 32'd15);
    check_eq("t4_xor_ill", 32'(illegal), 32'd1);
    check_eq("t4_xor_dst", 32'(dst_reg_addr), 32'd0);
    check_eq("t4_xor_imm", immediate_value, 32'd0);
    tick();

    // RV32E: x17 is out of range, x7 is fine
    e_in_valid = 1'b1; e_instr = 32'h00100893;
    tick();
    e_instr = 32'h00100393;
    check_eq("e_valid", 32'(e_out_valid), 32'd1);
    check_eq("e_x17_ill", 32'(e_illegal), 32'd1);
    check_eq("e_x17_ctrl", 32'(e_ctrl), 32'd15);
    check_eq("e_x17_dst", 32'(e_dst), 32'd0);
    tick();
    e_in_valid = 1'b0;
    check_eq("e_x7_ill", 32'(e_illegal), 32'd0);
    check_eq("e_x7_dst", 32'(e_dst), 32'd7);
    check_eq("e_ready", 32'(e_in_ready), 32'd1);
    tick();

    // Back-pressure: two accepted, third waits, then all drain one per cycle
    drive(1'b1, 32'h00100513, 1'b0, 1'b0, 5'd0, 1'b0); tick();
    drive(1'b1, 32'h00200593, 1'b0, 1'b0, 5'd0, 1'b0); tick();
    drive(1'b1, 32'h00300613, 1'b0, 1'b0, 5'd0, 1'b0);
    check_eq("t5_full", 32'(in_ready), 32'd0);
    tick();
    drive(1'b1, 32'h00300613, 1'b1, 1'b0, 5'd0, 1'b0);
    check_eq("t5_first", {31'(dst_reg_addr), out_valid}, {31'd10, 1'b1});
    tick();
    drive(1'b1, 32'h00300613, 1'b1, 1'b0, 5'd0, 1'b0);
    check_eq("t5_second", {31'(dst_reg_addr), out_valid}, {31'd11, 1'b1});
    check_eq("t5_ready_back", 32'(in_ready), 32'd1);
    tick();
    drive(1'b0, 32'h0, 1'b1, 1'b0, 5'd0, 1'b0);
    check_eq("t5_third", {31'(dst_reg_addr), out_valid}, {31'd12, 1'b1});
    tick();
    wb_clear(5'd10); wb_clear(5'd11); wb_clear(5'd12);

    // Flush with both entries full keeps the scoreboard
    drive(1'b1, 32'h00700293, 1'b1, 1'b0, 5'd0, 1'b0); tick();
    drive(1'b0, 32'h0, 1'b1, 1'b0, 5'd0, 1'b0); tick();
    drive(1'b1, 32'h00100513, 1'b0, 1'b0, 5'd0, 1'b0); tick();
    drive(1'b1, 32'h00200593, 1'b0, 1'b0, 5'd0, 1'b0); tick();
    drive(1'b1, 32'h00300613, 1'b0, 1'b0, 5'd0, 1'b1);
    check_eq("t6_pre_ready", 32'(in_ready), 32'd0);
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 5'd0, 1'b0);
    check_eq("t6_flush_valid", 32'(out_valid), 32'd0);
    check_eq("t6_flush_ready", 32'(in_ready), 32'd1);
    tick();
    drive(1'b1, 32'h00028333, 1'b1, 1'b0, 5'd0, 1'b0); tick();
    drive(1'b1, 32'h00100513, 1'b0, 1'b0, 5'd0, 1'b0);
    check_eq("t6_busy_kept", 32'(out_valid), 32'd0);
    tick();
    drive(1'b1, 32'h00200593, 1'b0, 1'b0, 5'd0, 1'b0);
    #2 reset = 1'b1;
    #1;
    check_eq("t6_rst_valid", 32'(out_valid), 32'd0);
    check_eq("t6_rst_ready", 32'(in_ready), 32'd1);
    check_eq("t6_rst_dst", 32'(dst_reg_addr), 32'd0);
    mq.delete();
    foreach (mbusy[i]) mbusy[i] = 1'b0;
    @(posedge clk);
    #1 reset = 1'b0;
    drive(1'b1, 32'h00028333, 1'b1, 1'b0, 5'd0, 1'b0); tick();
    drive(1'b0, 32'h0, 1'b1, 1'b0, 5'd0, 1'b0);
    check_eq("t6_busy_cleared", 32'(out_valid), 32'd1);
    tick();

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      logic [6:0] ops [10];
      ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h17, 7'h37, 7'h6f, 7'h67, 7'h7f};
      ins = $urandom;
      if ($urandom_range(0, 9) != 0) ins[6:0] = ops[$urandom_range(0, 9)];
      if ($urandom_range(0, 3) != 0) begin
        ins[11:7]  = 5'($urandom_range(0, 7));
        ins[19:15] = 5'($urandom_range(0, 7));
        ins[24:20] = 5'($urandom_range(0, 7));
      end
      case ($urandom_range(0, 3))
        0: ins[31:25] = 7'h00;
        1: ins[31:25] = 7'h20;
        default: ;
      endcase
      drive(1'($urandom_range(0, 3) != 0), ins, 1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
            1'($urandom_range(0, 49) == 0));
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
